// File: rtl/exu_ldst_pkg.sv
// Shared types and formatting helpers for the EXU load/store sequencer.
// Store lane replication / byte enables and load extraction / extension live here.
package exu_ldst_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RSP,
        S_WB
    } ldst_state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // funct3[1:0] encodes access size for both loads and stores
    function automatic logic ldst_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        case (f3[1:0])
            2'b01:   m = a[0];
            2'b10:   m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic ldst_illegal(input logic is_st, input logic [2:0] f3);
        return is_st ? (f3 > F3_SW) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    endfunction

    function automatic logic [35:0] st_fmt(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] wd);
        logic [31:0] d;
        logic [3:0]  s;
        case (f3)
            F3_SB: begin
                d = {4{wd[7:0]}};
                s = 4'b0001 << a;
            end
            F3_SH: begin
                d = {2{wd[15:0]}};
                s = 4'b0011 << a;
            end
            default: begin
                d = wd;
                s = 4'b1111;
            end
        endcase
        return {d, s};
    endfunction

    function automatic logic [31:0] ld_fmt(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rd >> {a, 3'b000};
        case (f3)
            F3_LB:   r = {{24{sh[7]}}, sh[7:0]};
            F3_LH:   r = {{16{sh[15]}}, sh[15:0]};
            F3_LBU:  r = {24'd0, sh[7:0]};
            F3_LHU:  r = {16'd0, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exu_ldst_fmt.sv
// Combinational store/load data formatter driven by the captured access fields.
module exu_ldst_fmt
    import exu_ldst_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  a_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wstrb_o,
    output logic [31:0] ld_data_o
);

    assign {st_wdata_o, st_wstrb_o} = st_fmt(funct3_i, a_i, wdata_i);
    assign ld_data_o                = ld_fmt(funct3_i, a_i, rdata_i);

endmodule

// File: rtl/exu_ldst_ctrl.sv
// Single-outstanding load/store sequencer: issue -> bus request -> response -> write-back.
// All handshake and exception outputs are registered.
module exu_ldst_ctrl
    import exu_ldst_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TMO_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_vld,
    output logic            iss_rdy,
    input  logic            iss_is_st,
    input  logic [2:0]      iss_funct3,
    input  logic [XLEN-1:0] iss_addr,
    input  logic [XLEN-1:0] iss_wdata,
    input  logic [4:0]      iss_rd,
    output logic            ldst_req_vld,
    input  logic            ldst_req_rdy,
    output logic            ldst_req_wr,
    output logic [XLEN-1:0] ldst_req_addr,
    output logic [XLEN-1:0] ldst_req_wdata,
    output logic [3:0]      ldst_req_wstrb,
    input  logic            ldst_rsp_vld,
    output logic            ldst_rsp_rdy,
    input  logic [XLEN-1:0] ldst_rsp_rdata,
    output logic            wb_vld,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exc_misalign,
    output logic            exc_bus_tmo
);

    localparam int CW = 16;

    ldst_state_e     state_q;
    logic            st_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [4:0]      rd_q;
    logic [CW-1:0]   cnt_q;
    logic            drain_q;
    logic            iss_rdy_q, req_vld_q, rsp_rdy_q;
    logic            wb_vld_q, exc_mis_q, exc_tmo_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    logic [XLEN-1:0] fmt_wdata, fmt_ldata;
    logic [3:0]      fmt_wstrb;

    exu_ldst_fmt u_fmt (
        .funct3_i   (f3_q),
        .a_i        (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rdata_i    (ldst_rsp_rdata),
        .st_wdata_o (fmt_wdata),
        .st_wstrb_o (fmt_wstrb),
        .ld_data_o  (fmt_ldata)
    );

    logic iss_fire, iss_bad, tmo_hit;
    assign iss_fire = iss_vld & iss_rdy_q;
    assign iss_bad  = ldst_illegal(iss_is_st, iss_funct3)
                    | ldst_misaligned(iss_funct3, iss_addr[1:0]);
    assign tmo_hit  = (TMO_CYC != 0) && (cnt_q == CW'(TMO_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            st_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            drain_q   <= 1'b0;
            iss_rdy_q <= 1'b1;
            req_vld_q <= 1'b0;
            rsp_rdy_q <= 1'b0;
            wb_vld_q  <= 1'b0;
            exc_mis_q <= 1'b0;
            exc_tmo_q <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            wb_vld_q  <= 1'b0;
            exc_mis_q <= 1'b0;
            exc_tmo_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // a response left over from a timed-out access is swallowed here
                    if (drain_q && ldst_rsp_vld) begin
                        drain_q   <= 1'b0;
                        rsp_rdy_q <= 1'b0;
                    end
                    if (iss_fire) begin
                        st_q    <= iss_is_st;
                        f3_q    <= iss_funct3;
                        addr_q  <= iss_addr;
                        wdata_q <= iss_wdata;
                        rd_q    <= iss_rd;
                        if (iss_bad) begin
                            exc_mis_q <= 1'b1;
                        end else begin
                            state_q   <= S_REQ;
                            iss_rdy_q <= 1'b0;
                            req_vld_q <= 1'b1;
                            rsp_rdy_q <= 1'b0;
                            drain_q   <= 1'b0;
                        end
                    end
                end
                S_REQ: begin
                    if (ldst_req_rdy) begin
                        state_q   <= S_RSP;
                        req_vld_q <= 1'b0;
                        rsp_rdy_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                S_RSP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (ldst_rsp_vld) begin
                        rsp_rdy_q <= 1'b0;
                        if (st_q) begin
                            state_q   <= S_IDLE;
                            iss_rdy_q <= 1'b1;
                        end else begin
                            state_q   <= S_WB;
                            wb_vld_q  <= (rd_q != 5'd0);
                            wb_rd_q   <= rd_q;
                            wb_data_q <= fmt_ldata;
                        end
                    end else if (tmo_hit) begin
                        state_q   <= S_IDLE;
                        iss_rdy_q <= 1'b1;
                        exc_tmo_q <= 1'b1;
                        drain_q   <= 1'b1;
                    end
                end
                S_WB: begin
                    state_q   <= S_IDLE;
                    iss_rdy_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign iss_rdy        = iss_rdy_q;
    assign ldst_req_vld   = req_vld_q;
    assign ldst_req_wr    = req_vld_q & st_q;
    assign ldst_req_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign ldst_req_wdata = st_q ? fmt_wdata : '0;
    assign ldst_req_wstrb = st_q ? fmt_wstrb : 4'b0000;
    assign ldst_rsp_rdy   = rsp_rdy_q;
    assign wb_vld         = wb_vld_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign exc_misalign   = exc_mis_q;
    assign exc_bus_tmo    = exc_tmo_q;

endmodule

// File: tb/tb_exu_ldst_ctrl.sv
// Directed bench for exu_ldst_ctrl; inputs driven and outputs checked on the falling edge.
module tb_exu_ldst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_vld, iss_rdy, iss_is_st;
    logic [2:0]  iss_funct3;
    logic [31:0] iss_addr, iss_wdata;
    logic [4:0]  iss_rd;
    logic        ldst_req_vld, ldst_req_rdy, ldst_req_wr;
    logic [31:0] ldst_req_addr, ldst_req_wdata;
    logic [3:0]  ldst_req_wstrb;
    logic        ldst_rsp_vld, ldst_rsp_rdy;
    logic [31:0] ldst_rsp_rdata;
    logic        wb_vld;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_misalign, exc_bus_tmo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exu_ldst_ctrl #(.XLEN(32), .TMO_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_vld(iss_vld), .iss_rdy(iss_rdy), .iss_is_st(iss_is_st),
        .iss_funct3(iss_funct3), .iss_addr(iss_addr), .iss_wdata(iss_wdata), .iss_rd(iss_rd),
        .ldst_req_vld(ldst_req_vld), .ldst_req_rdy(ldst_req_rdy), .ldst_req_wr(ldst_req_wr),
        .ldst_req_addr(ldst_req_addr), .ldst_req_wdata(ldst_req_wdata),
        .ldst_req_wstrb(ldst_req_wstrb),
        .ldst_rsp_vld(ldst_rsp_vld), .ldst_rsp_rdy(ldst_rsp_rdy), .ldst_rsp_rdata(ldst_rsp_rdata),
        .wb_vld(wb_vld), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_misalign(exc_misalign), .exc_bus_tmo(exc_bus_tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        iss_vld = 1'b1; iss_is_st = st; iss_funct3 = f3;
        iss_addr = addr; iss_wdata = wd; iss_rd = rd;
        @(negedge clk);
        iss_vld = 1'b0;
    endtask

    // min-latency load: req accepted immediately, rsp in the first RSP cycle
    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [4:0] rd, input logic [31:0] rdata,
                        input logic exp_wb, input logic [31:0] exp_data);
        ldst_req_rdy = 1'b1;
        issue(1'b0, f3, addr, 32'h0, rd);
        chk({tag, ".req_vld"}, ldst_req_vld, 1);
        chk({tag, ".req_addr"}, ldst_req_addr, {addr[31:2], 2'b00});
        chk({tag, ".wstrb"}, ldst_req_wstrb, 0);
        chk({tag, ".wr"}, ldst_req_wr, 0);
        chk({tag, ".iss_rdy_req"}, iss_rdy, 0);
        @(negedge clk);
        chk({tag, ".rsp_rdy"}, ldst_rsp_rdy, 1);
        ldst_rsp_vld = 1'b1; ldst_rsp_rdata = rdata;
        @(negedge clk);
        ldst_rsp_vld = 1'b0;
        chk({tag, ".wb_vld"}, wb_vld, exp_wb);
        if (exp_wb) begin
            chk({tag, ".wb_data"}, wb_data, exp_data);
            chk({tag, ".wb_rd"}, wb_rd, rd);
        end
        chk({tag, ".iss_rdy_wb"}, iss_rdy, 0);
        @(negedge clk);
        chk({tag, ".wb_drop"}, wb_vld, 0);
        chk({tag, ".iss_rdy_idle"}, iss_rdy, 1);
    endtask

    task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_wd,
                         input logic [3:0] exp_strb);
        ldst_req_rdy = 1'b1;
        issue(1'b1, f3, addr, wd, 5'd9);
        chk({tag, ".req_vld"}, ldst_req_vld, 1);
        chk({tag, ".wr"}, ldst_req_wr, 1);
        chk({tag, ".req_addr"}, ldst_req_addr, {addr[31:2], 2'b00});
        chk({tag, ".wdata"}, ldst_req_wdata, exp_wd);
        chk({tag, ".wstrb"}, ldst_req_wstrb, exp_strb);
        @(negedge clk);
        ldst_rsp_vld = 1'b1; ldst_rsp_rdata = 32'h0;
        @(negedge clk);
        ldst_rsp_vld = 1'b0;
        chk({tag, ".no_wb"}, wb_vld, 0);
        chk({tag, ".iss_rdy"}, iss_rdy, 1);
    endtask

    task automatic bad(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr);
        issue(st, f3, addr, 32'h0, 5'd3);
        chk({tag, ".exc"}, exc_misalign, 1);
        chk({tag, ".no_req"}, ldst_req_vld, 0);
        chk({tag, ".iss_rdy"}, iss_rdy, 1);
        @(negedge clk);
        chk({tag, ".exc_pulse"}, exc_misalign, 0);
        chk({tag, ".no_req2"}, ldst_req_vld, 0);
    endtask

    initial begin
        rst_n = 1'b0; iss_vld = 1'b0; iss_is_st = 1'b0; iss_funct3 = 3'd0;
        iss_addr = 32'h0; iss_wdata = 32'h0; iss_rd = 5'd0;
        ldst_req_rdy = 1'b0; ldst_rsp_vld = 1'b0; ldst_rsp_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.iss_rdy", iss_rdy, 1);
        chk("rst.req_vld", ldst_req_vld, 0);
        chk("rst.rsp_rdy", ldst_rsp_rdy, 0);
        chk("rst.wb_vld", wb_vld, 0);
        chk("rst.req_addr", ldst_req_addr, 0);
        chk("rst.wdata", ldst_req_wdata, 0);
        chk("rst.exc", {exc_misalign, exc_bus_tmo}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW with one idle RSP cycle before the response
        ldst_req_rdy = 1'b1;
        issue(1'b0, 3'd2, 32'h100, 32'h0, 5'd5);
        chk("lw.req_vld", ldst_req_vld, 1);
        chk("lw.req_addr", ldst_req_addr, 32'h100);
        chk("lw.wstrb", ldst_req_wstrb, 0);
        chk("lw.iss_rdy0", iss_rdy, 0);
        @(negedge clk);
        chk("lw.iss_rdy1", iss_rdy, 0);
        chk("lw.req_drop", ldst_req_vld, 0);
        @(negedge clk);
        chk("lw.iss_rdy2", iss_rdy, 0);
        chk("lw.early_wb", wb_vld, 0);
        ldst_rsp_vld = 1'b1; ldst_rsp_rdata = 32'hDEADBEEF;
        @(negedge clk);
        ldst_rsp_vld = 1'b0;
        chk("lw.wb_vld", wb_vld, 1);
        chk("lw.wb_data", wb_data, 32'hDEADBEEF);
        chk("lw.wb_rd", wb_rd, 5);
        chk("lw.iss_rdy3", iss_rdy, 0);
        @(negedge clk);
        chk("lw.wb_pulse", wb_vld, 0);
        chk("lw.iss_rdy4", iss_rdy, 1);

        load("lb",  3'd0, 32'h103, 5'd6, 32'h80112233, 1'b1, 32'hFFFFFF80);
        load("lbu", 3'd4, 32'h103, 5'd6, 32'h80112233, 1'b1, 32'h00000080);
        load("lhu", 3'd5, 32'h102, 5'd7, 32'h80112233, 1'b1, 32'h00008011);
        load("lh",  3'd1, 32'h102, 5'd7, 32'h80112233, 1'b1, 32'hFFFF8011);
        load("lb0", 3'd0, 32'h100, 5'd8, 32'h80112233, 1'b1, 32'h00000033);

        store("sh", 3'd1, 32'h202, 32'h1234ABCD, 32'hABCDABCD, 4'b1100);
        store("sb", 3'd0, 32'h201, 32'h0000005A, 32'h5A5A5A5A, 4'b0010);
        store("sw", 3'd2, 32'h204, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111);

        bad("lw_mis", 1'b0, 3'd2, 32'h101);
        bad("lh_mis", 1'b0, 3'd1, 32'h103);
        bad("ld_f3_3", 1'b0, 3'd3, 32'h100);
        bad("ld_f3_6", 1'b0, 3'd6, 32'h100);
        bad("st_f3_4", 1'b1, 3'd4, 32'h100);

        // timeout after 4 RSP cycles, then a late response is discarded
        ldst_req_rdy = 1'b1;
        issue(1'b0, 3'd2, 32'h300, 32'h0, 5'd7);
        chk("tmo.req_vld", ldst_req_vld, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tmo.wait_exc", exc_bus_tmo, 0);
            chk("tmo.wait_rdy", ldst_rsp_rdy, 1);
        end
        @(negedge clk);
        chk("tmo.exc", exc_bus_tmo, 1);
        chk("tmo.iss_rdy", iss_rdy, 1);
        chk("tmo.rsp_rdy", ldst_rsp_rdy, 1);
        ldst_rsp_vld = 1'b1; ldst_rsp_rdata = 32'h12345678;
        @(negedge clk);
        ldst_rsp_vld = 1'b0;
        chk("tmo.exc_pulse", exc_bus_tmo, 0);
        chk("tmo.late_wb", wb_vld, 0);
        chk("tmo.drained", ldst_rsp_rdy, 0);
        @(negedge clk);
        chk("tmo.late_wb2", wb_vld, 0);
        chk("tmo.no_req", ldst_req_vld, 0);

        // request stalled, then reset mid-access
        ldst_req_rdy = 1'b0;
        issue(1'b0, 3'd2, 32'h400, 32'h0, 5'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall.req_vld", ldst_req_vld, 1);
            chk("stall.req_addr", ldst_req_addr, 32'h400);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid.req_vld", ldst_req_vld, 0);
        chk("rst_mid.iss_rdy", iss_rdy, 1);
        chk("rst_mid.addr", ldst_req_addr, 0);

        load("x0", 3'd2, 32'h104, 5'd0, 32'h55AA55AA, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exu_ldst_ctrl.md
Name: exu_ldst_ctrl

Overview:
Sequencer for the EXU load/store path. It accepts one load or store at a time from EXU decode and checks alignment. It drives the ldst master request/response handshake, then formats and issues the register write-back. While an access is in flight it back-pressures EXU issue, so the single memory port is never over-subscribed.

Parameters:
XLEN, 32, data/address width (only 32 supported)
TMO_CYC, 255, max cycles waiting for a response; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
iss_vld  in  1  load/store issue valid from decode
iss_rdy  out  1  controller can accept issue
iss_is_st  in  1  1=store, 0=load
iss_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
iss_addr  in  XLEN  effective address (rs1+imm, computed upstream)
iss_wdata  in  XLEN  rs2 value for stores
iss_rd  in  5  load destination register
ldst_req_vld  out  1  memory request valid
ldst_req_rdy  in  1  memory request ready
ldst_req_wr  out  1  1=write
ldst_req_addr  out  XLEN  word-aligned address (addr[1:0]=0)
ldst_req_wdata  out  XLEN  lane-replicated store data
ldst_req_wstrb  out  4  byte enables (0 for reads)
ldst_rsp_vld  in  1  response valid
ldst_rsp_rdy  out  1  response ready
ldst_rsp_rdata  in  XLEN  read data (full word)
wb_vld  out  1  register write-back strobe (1 cycle)
wb_rd  out  5  write-back register
wb_data  out  XLEN  extended load result
exc_misalign  out  1  1-cycle pulse: misaligned access, no bus activity
exc_bus_tmo  out  1  1-cycle pulse: response timeout

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. All outputs are 0 except iss_rdy=1. The timeout counter is 0. All captured fields are 0.
- FSM states: IDLE, REQ, RSP, WB.
- IDLE:
  - iss_rdy=1. On iss_vld&iss_rdy, capture is_st, funct3, addr, wdata, rd.
  - Misaligned means: halfword with addr[0]!=0, or word with addr[1:0]!=0. On misaligned, pulse exc_misalign in the next cycle and stay IDLE. The instruction is consumed.
  - Otherwise go to REQ.
- REQ:
  - ldst_req_vld=1, with fields taken from the captured registers (stable while vld&!rdy).
  - On ldst_req_rdy: a load goes to RSP; a store goes to RSP as well, and the write acknowledge is consumed via rsp.
  - iss_rdy=0.
- RSP:
  - ldst_rsp_rdy=1. The counter increments each cycle.
  - On ldst_rsp_vld: a load goes to WB with the formatted data registered; a store goes to IDLE.
  - If TMO_CYC!=0 and counter==TMO_CYC-1 with no rsp: pulse exc_bus_tmo and go to IDLE. A late response arriving in IDLE is accepted and discarded (rsp_rdy=1 in IDLE).
- WB: wb_vld=1 for exactly one cycle, then IDLE. If rd==0, wb_vld is still 0 (x0 never written).
- Latency: issue to req_vld is 1 cycle; rsp_vld to wb_vld is 1 cycle. Minimum load is 4 cycles issue-to-issue; minimum store is 3.
- Store formatting:
  - SB: wdata={4{b}}, wstrb=0001<<a.
  - SH: wdata={2{h}}, wstrb=0011<<a.
  - SW: wstrb=1111.
  - a=addr[1:0].
- Load formatting: shift rdata right by a*8. LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word as-is.
- Invalid funct3 (3, 6, 7 for loads; 3 and up for stores) raises exc_misalign. No bus access occurs.
- The counter clears on every REQ to RSP transition.
- Reset mid-access: the FSM returns to IDLE and outputs drop immediately. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package exu_ldst_pkg holds:
  - the state enum;
  - funct3 constants (F3_LB..F3_SW);
  - function ldst_misaligned(funct3, addr[1:0]);
  - functions st_fmt(funct3, a, wdata) -> {wdata, wstrb} and ld_fmt(funct3, a, rdata).
- One combinational sub-module, exu_ldst_fmt, implements st_fmt and ld_fmt.

Test Plan:
- LW at 0x100, req_rdy=1, rsp 2 cycles later with rdata=0xDEADBEEF, rd=5 -> req addr=0x100 wstrb=0; wb_vld one cycle after rsp with wb_data=0xDEADBEEF, wb_rd=5; iss_rdy=0 throughout.
- LB at 0x103 with rdata=0x80112233 -> wb_data=0xFFFFFF80. LBU same -> 0x00000080. LHU at 0x102 -> 0x00008011.
- SH at 0x202, wdata=0x1234ABCD -> req addr=0x200, wdata=0xABCDABCD, wstrb=1100, wr=1; no wb_vld after rsp.
- LW at 0x101 -> exc_misalign pulse, no ldst_req_vld, iss_rdy back to 1 next cycle.
- TMO_CYC=4, LW with rsp withheld -> exc_bus_tmo after 4 RSP cycles, then IDLE. A later rsp_vld is dropped with no wb_vld.
- req_rdy held low 5 cycles, then rst_n=0 -> req_vld=0, iss_rdy=1 after the reset edge; LW to rd=0 -> no wb_vld.
